// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, byte-lane positions, state and opcode encodings
// for the memory port master.
//   ADDR_W / DATA_W : byte address and word widths
//   HI_* / LO_*     : big-endian lanes; HI is the byte at addr, LO is addr+1
//   state_t         : master FSM states
//   op_t            : request opcode {req_write, req_byte}
//   byte_load()     : places the HI byte in [7:0], zero- or sign-extended
package mem_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int BYTE_W = 8;
    localparam int HI_MSB = 15;
    localparam int HI_LSB = 8;
    localparam int LO_MSB = 7;
    localparam int LO_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    typedef enum logic [1:0] {
        OP_LD_WORD = 2'b00,
        OP_LD_BYTE = 2'b01,
        OP_ST_WORD = 2'b10,
        OP_ST_BYTE = 2'b11
    } op_t;

    function automatic logic [DATA_W-1:0] byte_load(input logic [DATA_W-1:0] word,
                                                    input logic sign_ext);
        return {{BYTE_W{sign_ext & word[HI_MSB]}}, word[HI_MSB:HI_LSB]};
    endfunction
endpackage

// File: rtl/mem_we_pulse_gen.sv
// mem_we_pulse_gen: registered write-enable pulse generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : strobe; we rises on the next rising edge
//   we         : flop output, high for exactly WE_CYCLES cycles
//   done       : one-cycle strobe in the cycle after we falls
module mem_we_pulse_gen #(
    parameter int WE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic we,
    output logic done
);
    localparam logic [3:0] CNT_LOAD = 4'(WE_CYCLES - 1);

    logic       we_q, we_d;
    logic       done_q, done_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        we_d   = we_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            we_d  = 1'b1;
            cnt_d = CNT_LOAD;
        end else if (we_q) begin
            // cnt_q counts the remaining high cycles after the current one
            we_d   = (cnt_q != 4'd0);
            done_d = (cnt_q == 4'd0);
            cnt_d  = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else begin
            we_q   <= we_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
        end
    end

    assign we   = we_q;
    assign done = done_q;
endmodule

// File: rtl/mem_port_master.sv
// mem_port_master: turns a valid/ready load/store request stream into safely
// timed cycles on one port of a big-endian byte-addressed 16-bit memory.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_write, req_byte   : store/load, byte/word
//   req_addr, req_wdata   : byte address, store data (byte stores use [7:0])
//   rsp_valid, rsp_rdata  : one-cycle completion pulse, load data (0 for stores)
//   mem_addr, mem_wdata   : memory address and write data, held through writes
//   mem_we                : registered write-enable pulse of WE_CYCLES cycles
//   mem_rdata             : combinational memory read data
module mem_port_master
    import mem_pkg::*;
#(
    parameter int WE_CYCLES     = 1,
    parameter bit SIGN_EXT_BYTE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t            state_q, state_d;
    logic              byte_q, byte_d;
    logic [BYTE_W-1:0] wbyte_q, wbyte_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              pulse_start, pulse_done;
    op_t               op;

    assign op = op_t'({req_write, req_byte});

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        wbyte_d     = wbyte_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_valid_d = 1'b0;
        pulse_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mem_addr_d  = req_addr;
                    byte_d      = req_byte;
                    wbyte_d     = req_wdata[LO_MSB:LO_LSB];
                    mem_wdata_d = (op == OP_ST_WORD) ? req_wdata : mem_wdata_q;
                    state_d     = (op == OP_ST_BYTE) ? RMW_RD :
                                  (op == OP_ST_WORD) ? WR_SETUP : RD;
                end
            end
            RD: begin
                rsp_rdata_d = byte_q ? byte_load(mem_rdata, SIGN_EXT_BYTE) : mem_rdata;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            RMW_RD: begin
                // the neighbouring byte at addr+1 is written back unchanged
                mem_wdata_d = {wbyte_q, mem_rdata[LO_MSB:LO_LSB]};
                state_d     = WR_SETUP;
            end
            WR_SETUP: begin
                pulse_start = 1'b1;
                state_d     = WR_PULSE;
            end
            WR_PULSE: begin
                state_d = pulse_done ? WR_HOLD : WR_PULSE;
            end
            WR_HOLD: begin
                rsp_rdata_d = '0;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_q      <= 1'b0;
            wbyte_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            wbyte_q     <= wbyte_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    mem_we_pulse_gen #(
        .WE_CYCLES(WE_CYCLES)
    ) u_we_pulse (
        .clk  (clk),
        .rst_n(rst_n),
        .start(pulse_start),
        .we   (mem_we),
        .done (pulse_done)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_master.sv
// tb_mem_port_master: two masters (WE_CYCLES=1 zero-extend, WE_CYCLES=3 sign-extend),
// each on its own byte memory, checked against a byte-array reference model.
module tb_mem_port_master;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_write, req_byte, rsp_valid, mem_we;
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic [15:0] rsp_rdata [2];
    logic [15:0] mem_addr  [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];
    logic [7:0]  ref_mem [2][65536];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] mem [65536];
        mem_port_master #(
            .WE_CYCLES    (g == 0 ? 1 : 3),
            .SIGN_EXT_BYTE(g == 1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_write(req_write[g]),
            .req_byte (req_byte[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_we   (mem_we[g]),
            .mem_rdata(mem_rdata[g])
        );
        initial for (int j = 0; j < 65536; j++) mem[j] = 8'h00;
        always @(posedge mem_we[g]) begin
            mem[mem_addr[g]]         <= mem_wdata[g][15:8];
            mem[mem_addr[g] + 16'd1] <= mem_wdata[g][7:0];
        end
        assign mem_rdata[g] = {mem[mem_addr[g]], mem[mem_addr[g] + 16'd1]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_load(input int i, input bit b, input logic [15:0] a);
        logic [15:0] a1, word;
        a1   = a + 16'd1;
        word = {ref_mem[i][a], ref_mem[i][a1]};
        if (!b) return word;
        return {(i == 1 && word[15]) ? 8'hFF : 8'h00, word[15:8]};
    endfunction

    task automatic ref_store(input int i, input bit b, input logic [15:0] a, input logic [15:0] d);
        logic [15:0] a1;
        a1 = a + 16'd1;
        if (b) ref_mem[i][a] = d[7:0];
        else begin
            ref_mem[i][a]  = d[15:8];
            ref_mem[i][a1] = d[7:0];
        end
    endtask

    // Called at a negedge with the port idle; returns at a negedge with it idle again.
    task automatic do_req(input int i, input bit w, input bit b, input logic [15:0] a,
                          input logic [15:0] d);
        logic [15:0] a1, exp_rd, exp_wd;
        int k, we_n, we_first, we_last, wc;
        bit stable;
        a1       = a + 16'd1;
        wc       = (i == 1) ? 3 : 1;
        exp_wd   = b ? {d[7:0], ref_mem[i][a1]} : d;
        exp_rd   = w ? 16'h0000 : ref_load(i, b, a);
        check("req_ready_idle", req_ready[i], 1);
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_byte[i]  = b;
        req_addr[i]  = a;
        req_wdata[i] = d;
        @(negedge clk);
        req_valid[i] = 1'b0;
        req_addr[i]  = 16'($urandom);
        req_wdata[i] = 16'($urandom);
        k = 0; we_n = 0; we_first = -1; we_last = -1; stable = 1'b1;
        while (!rsp_valid[i] && k < 40) begin
            if (mem_we[i]) begin
                we_n++;
                if (we_first < 0) we_first = k;
                we_last = k;
            end
            if (mem_addr[i] !== a) stable = 1'b0;
            if (w && k >= (b ? 1 : 0) && mem_wdata[i] !== exp_wd) stable = 1'b0;
            @(negedge clk);
            k++;
        end
        check("rsp_latency", k, w ? (b ? 4 + wc : 3 + wc) : 1);
        check("rsp_rdata", rsp_rdata[i], exp_rd);
        check("we_cycles", we_n, w ? wc : 0);
        check("addr_data_stable", stable, 1);
        if (w) begin
            check("we_first", we_first, b ? 2 : 1);
            check("we_contiguous", we_last - we_first + 1, wc);
            ref_store(i, b, a, d);
        end
        @(negedge clk);
        check("rsp_single_pulse", rsp_valid[i], 0);
    endtask

    initial begin
        logic [15:0] ba [3];
        logic [15:0] bexp [3];
        int acc [3];
        int n_acc, n_rsp, low, k, rsp_seen, ri;
        bit rw, rb;
        logic [15:0] ra;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 65536; j++) ref_mem[i][j] = 8'h00;
        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_byte  = '0;
        for (int i = 0; i < 2; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_mem_addr", mem_addr[i], 0);
            check("rst_mem_wdata", mem_wdata[i], 0);
            check("rst_mem_we", mem_we[i], 0);
            check("rst_rsp_valid", rsp_valid[i], 0);
            check("rst_rsp_rdata", rsp_rdata[i], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready0", req_ready[0], 1);
        check("rst_req_ready1", req_ready[1], 1);

        do_req(0, 1, 0, 16'h0010, 16'hBEEF);
        do_req(0, 0, 0, 16'h0010, 16'h0000);
        do_req(0, 1, 0, 16'h0020, 16'h1234);
        do_req(0, 1, 1, 16'h0020, 16'h00AB);
        do_req(0, 0, 0, 16'h0020, 16'h0000);
        do_req(0, 1, 1, 16'h0020, 16'hFF85);
        do_req(0, 0, 1, 16'h0020, 16'h0000);
        do_req(1, 1, 1, 16'h0020, 16'h0085);
        do_req(1, 0, 1, 16'h0020, 16'h0000);
        do_req(0, 1, 0, 16'hFFFF, 16'h5566);
        do_req(0, 0, 0, 16'hFFFF, 16'h0000);
        do_req(0, 0, 1, 16'h0000, 16'h0000);
        do_req(0, 1, 1, 16'hFFFF, 16'h0077);
        do_req(0, 0, 0, 16'hFFFF, 16'h0000);
        do_req(1, 1, 0, 16'h0030, 16'hC3A5);
        do_req(1, 0, 0, 16'h0030, 16'h0000);
        check("tp_beef", ref_load(0, 0, 16'h0010), 16'hBEEF);
        check("tp_wrap", ref_load(0, 0, 16'hFFFF), 16'h7766);

        // three loads with req_valid held high throughout
        ba = '{16'h0010, 16'h0020, 16'hFFFF};
        for (int j = 0; j < 3; j++) bexp[j] = ref_load(0, 0, ba[j]);
        n_acc = 0; n_rsp = 0; low = 0;
        req_write[0] = 1'b0;
        req_byte[0]  = 1'b0;
        req_addr[0]  = ba[0];
        req_valid[0] = 1'b1;
        for (int c = 0; c < 30 && n_rsp < 3; c++) begin
            if (rsp_valid[0]) begin
                check("b2b_rdata", rsp_rdata[0], bexp[n_rsp]);
                n_rsp++;
            end
            if (!req_ready[0]) low++;
            if (req_valid[0] && req_ready[0] && n_acc < 3) begin
                acc[n_acc] = c;
                n_acc++;
            end
            @(negedge clk);
            if (n_acc == 3) req_valid[0] = 1'b0;
            else req_addr[0] = ba[n_acc];
        end
        req_valid[0] = 1'b0;
        check("b2b_rsp_count", n_rsp, 3);
        check("b2b_accept_count", n_acc, 3);
        check("b2b_accept_gap1", acc[1] - acc[0], 2);
        check("b2b_accept_gap2", acc[2] - acc[1], 2);
        check("b2b_ready_low_cycles", low, 3);
        @(negedge clk);

        // reset during the second mem_we cycle of a WE_CYCLES=3 store
        req_write[1] = 1'b1;
        req_byte[1]  = 1'b0;
        req_addr[1]  = 16'h0100;
        req_wdata[1] = 16'h9A7C;
        req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        k = 0;
        while (!mem_we[1] && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_we_rose", mem_we[1], 1);
        @(negedge clk);
        check("rst_mid_we_2nd", mem_we[1], 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_we_drop", mem_we[1], 0);
        check("rst_mid_rsp_valid", rsp_valid[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_store(1, 0, 16'h0100, 16'h9A7C);
        rsp_seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid[1] || mem_we[1]) rsp_seen++;
            @(negedge clk);
        end
        check("rst_mid_no_rsp", rsp_seen, 0);
        check("rst_mid_ready", req_ready[1], 1);
        do_req(1, 0, 0, 16'h0100, 16'h0000);

        for (int n = 0; n < 150; n++) begin
            ri = int'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 1))
                                             : 16'h0040 + 16'($urandom_range(0, 7));
            do_req(ri, rw, rb, ra, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
